// File: rtl/sw_debounce8_pkg.sv
// Shared defaults and helpers for the eight-switch-plus-enable debouncer.
package sw_debounce8_pkg;

  localparam int DEBOUNCE_CYCLES_DEF = 16;
  localparam int SYNC_STAGES_DEF     = 2;
  localparam int NUM_CH              = 9;

  // Smallest width whose range covers 0..cycles-1 (minimum 1 bit).
  function automatic int cnt_width(input int cycles);
    int w;
    w = 1;
    for (int i = 1; i <= 16; i++) begin
      if ((1 << i) < cycles) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/sw_debounce8_bit.sv
// One debounce channel: synchronizer, run-length counter and accepted level.
module debounce_bit
  import sw_debounce8_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int SYNC_STAGES     = SYNC_STAGES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_raw,
  output logic o_q
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] TERM = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [CW-1:0]          r_cnt;
  logic                   r_q;
  logic                   w_s;

  assign w_s = r_sync[SYNC_STAGES-1];
  assign o_q = r_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
      r_cnt  <= '0;
      r_q    <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_raw};
      if (w_s == r_q) begin
        r_cnt <= '0;
      end else if (r_cnt == TERM) begin
        // Terminal count clears the counter, so it can never wrap.
        r_q   <= w_s;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/sw_debounce8.sv
// Debounces eight switches plus an enable switch and flags accepted edges.
module sw_debounce8
  import sw_debounce8_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int SYNC_STAGES     = SYNC_STAGES_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] sw_in,
  input  logic       en_in,
  output logic [7:0] x,
  output logic       en,
  output logic [7:0] rise,
  output logic       chg
);

  logic [NUM_CH-1:0] w_raw;
  logic [NUM_CH-1:0] w_q;
  logic [NUM_CH-1:0] r_q_d;
  logic [7:0]        r_rise;
  logic              r_chg;

  assign w_raw = {en_in, sw_in};

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .SYNC_STAGES    (SYNC_STAGES)
    ) u_bit (
      .clk  (clk),
      .rst_n(rst_n),
      .i_raw(w_raw[c]),
      .o_q  (w_q[c])
    );
  end

  // Edge flags compare against last cycle's levels, so they land one cycle after x/en move.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q_d  <= '0;
      r_rise <= '0;
      r_chg  <= 1'b0;
    end else begin
      r_q_d  <= w_q;
      r_rise <= w_q[7:0] & ~r_q_d[7:0];
      r_chg  <= |(w_q ^ r_q_d);
    end
  end

  assign x    = w_q[7:0];
  assign en   = w_q[8];
  assign rise = r_rise;
  assign chg  = r_chg;

endmodule

// File: doc/sw_debounce8.md
SW_DEBOUNCE8 -- requirements
Module: sw_debounce8

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 16: consecutive synchronized samples needed to accept a level change; legal range 2..65535.
REQ-002 Parameter SYNC_STAGES, default 2: synchronizer depth per input; legal range 2..4.
REQ-003 Port list: one clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 sw_in  input  8  raw switch levels, asynchronous to clk, may bounce.
REQ-007 en_in  input  1  raw enable switch, asynchronous, may bounce.
REQ-008 x  output  8  debounced switch vector; feeds the 8-3 priority encoder data input.
REQ-009 en  output  1  debounced enable; feeds the encoder enable.
REQ-010 rise  output  8  one-cycle pulse per bit when x[i] goes 0->1.
REQ-011 chg  output  1  one-cycle pulse when any bit of x or en changes.

Function
REQ-012 Nine identical channels (sw_in[7:0], en_in), each with its own SYNC_STAGES-flop synchronizer, counter and stable register; no channel state is shared.
REQ-013 Per channel, each edge: synchronized sample s equals stable q -> counter cleared to 0.
REQ-014 Per channel, each edge: s differs from q and counter < DEBOUNCE_CYCLES-1 -> counter increments by 1.
REQ-015 Per channel, each edge: s differs from q and counter == DEBOUNCE_CYCLES-1 -> q takes s, counter cleared to 0.
REQ-016 Counter width is ceil(log2(DEBOUNCE_CYCLES)); it never wraps, since REQ-015 clears it at the terminal value.
REQ-017 Latency: an input held at a new level changes q on the (SYNC_STAGES+DEBOUNCE_CYCLES)-th rising edge, counting the first edge after the input change as edge 1.
REQ-018 Bounce: any return of s to q before the terminal count clears the counter; a pulse shorter than DEBOUNCE_CYCLES synchronized samples never reaches q.
REQ-019 x and en are registered q values only; no combinational path from sw_in or en_in to any output.
REQ-020 rise[i] is asserted in the cycle immediately after x[i] goes 0->1, for exactly one cycle; 1->0 transitions produce no pulse.
REQ-021 chg is asserted for one cycle in the cycle after any q update; simultaneous updates on several channels produce a single chg pulse.
REQ-022 rise and chg are registered, and the en channel does not drive rise.

Reset
REQ-023 rst_n low asynchronously forces all synchronizer flops, counters, x, en, rise and chg to 0.
REQ-024 Reset asserted mid-count discards the partial count; after release, each channel restarts from q=0 with counter 0.
REQ-025 After release, an input already high reaches x/en after the REQ-017 latency, with one rise/chg pulse, as for any 0->1 change.

Structure
REQ-026 Shared package holds DEBOUNCE_CYCLES_DEF=16, SYNC_STAGES_DEF=2 and the counter-width function.
REQ-027 One sub-module, debounce_bit (synchronizer, counter and stable register for one channel), is instantiated nine times; edge and chg logic live in the top.

Verification (bench uses DEBOUNCE_CYCLES=4, SYNC_STAGES=2)
REQ-028 Reset, then sw_in=8'h00 -> 8'h01 held -> x=8'h01 on edge 6; rise=8'h01 and chg=1 for one cycle on edge 7.
REQ-029 sw_in[3] toggles 1,0,1,0 every 2 cycles, then stays 0 -> x[3] remains 0, no rise, no chg.
REQ-030 sw_in=8'hFF and en_in=1 changed in the same cycle -> x=8'hFF and en=1 on the same edge; rise=8'hFF; exactly one chg pulse.
REQ-031 sw_in[7] driven high, rst_n pulsed low 3 edges later, input still high -> x=0 during reset; x[7]=1 on the 6th edge after release.
REQ-032 x=8'h80 stable, sw_in[7] driven 1->0 and held -> x[7]=0 after 6 edges; chg pulses and rise stays 0.
REQ-033 Random bouncy stimulus with a reference model -> x/en never change unless the synchronized input held its new value for 4 consecutive samples.
